// File: rtl/hamming_secded_codec.sv
// hamming_secded_codec: two-stage pipelined Hamming SECDED encoder/decoder with
// valid/ready streaming, per-beat encode/decode mode and saturating error counters.
module hamming_secded_codec #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16,
    localparam int PAR_W = $clog2(DATA_W + 1 + $clog2(DATA_W + 1 + $clog2(DATA_W + 1 + $clog2(DATA_W + 1)))),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [CODE_W-1:0] out_code,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_err_single,
    output logic              out_err_double,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double,
    input  logic              cnt_clr
);
    localparam int N = DATA_W + PAR_W;

    function automatic logic is_pow2(input int i);
        return (i & (i - 1)) == 0;
    endfunction

    function automatic logic [CODE_W-1:0] f_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int i = 1; i <= N; i++)
            if (!is_pow2(i)) begin
                c[i] = d[j];
                j++;
            end
        // parity slots are still zero here, so including them in the XOR is harmless
        for (int k = 0; k < PAR_W; k++)
            for (int i = 1; i <= N; i++)
                if (((i >> k) & 1) == 1) c[1 << k] = c[1 << k] ^ c[i];
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [PAR_W-1:0] f_syn(input logic [CODE_W-1:0] c);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int i = 1; i <= N; i++)
            if (c[i]) s = s ^ PAR_W'(i);
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] f_extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 1; i <= N; i++)
            if (!is_pow2(i)) begin
                d[j] = c[i];
                j++;
            end
        return d;
    endfunction

    logic              r_v1, r_mode1, r_par1;
    logic [CODE_W-1:0] r_code1;
    logic [PAR_W-1:0]  r_syn1;
    logic              r_v2, r_mode2, r_es2, r_ed2;
    logic [CODE_W-1:0] r_code2;
    logic [DATA_W-1:0] r_data2;
    logic [PAR_W-1:0]  r_syn2;
    logic [CNT_W-1:0]  r_cnt_s, r_cnt_d;
    logic              w_adv1, w_adv2, w_fire, w_single, w_double;
    logic [CODE_W-1:0] w_code;

    always_comb begin
        w_adv2   = !r_v2 || out_ready;
        w_adv1   = !r_v1 || w_adv2;
        w_fire   = r_v2 && out_ready && r_mode2;
        w_single = r_mode1 && r_par1 && int'(r_syn1) <= N;
        w_double = r_mode1 && (r_syn1 != '0) && (!r_par1 || int'(r_syn1) > N);
        // syndrome 0 with odd parity flips bit 0, the overall-parity bit
        w_code   = r_code1 ^ (w_single ? (CODE_W'(1) << r_syn1) : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_mode1 <= 1'b0;
            r_par1  <= 1'b0;
            r_code1 <= '0;
            r_syn1  <= '0;
        end else if (w_adv1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_mode1 <= mode_in;
                r_code1 <= mode_in ? in_data : f_encode(in_data[DATA_W-1:0]);
                r_syn1  <= mode_in ? f_syn(in_data) : '0;
                r_par1  <= mode_in && (^in_data);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_mode2 <= 1'b0;
            r_code2 <= '0;
            r_data2 <= '0;
            r_syn2  <= '0;
            r_es2   <= 1'b0;
            r_ed2   <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_mode2 <= r_mode1;
                r_code2 <= w_code;
                r_data2 <= f_extract(w_code);
                r_syn2  <= r_syn1;
                r_es2   <= w_single;
                r_ed2   <= w_double;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_s <= '0;
            r_cnt_d <= '0;
        end else if (cnt_clr) begin
            r_cnt_s <= '0;
            r_cnt_d <= '0;
        end else begin
            if (w_fire && r_es2 && r_cnt_s != '1) r_cnt_s <= r_cnt_s + 1'b1;
            if (w_fire && r_ed2 && r_cnt_d != '1) r_cnt_d <= r_cnt_d + 1'b1;
        end
    end

    assign in_ready       = w_adv1;
    assign out_valid      = r_v2;
    assign out_mode       = r_mode2;
    assign out_code       = r_code2;
    assign out_data       = r_data2;
    assign out_syndrome   = r_syn2;
    assign out_err_single = r_es2;
    assign out_err_double = r_ed2;
    assign cnt_single     = r_cnt_s;
    assign cnt_double     = r_cnt_d;
endmodule

// File: doc/hamming_secded_codec.md
Name: hamming_secded_codec

Overview:
- Parametrised, pipelined Hamming SECDED codec (single-error-correct, double-error-detect) with valid/ready streaming on both sides.
- A per-beat mode bit selects encode or decode, so one instance serves both the transmit and receive paths of the parity-checker subsystem.
- Successor to the fixed (7,4) combinational encoder: adds width generalisation, an overall-parity bit, decode/correction, backpressure and saturating error counters.

Parameters:
- DATA_W, 4: data bits per word, at least 2.
- PAR_W, derived localparam (not overridable): smallest r with 2^r >= DATA_W+r+1. Equals 3 for DATA_W=4.
- CODE_W, derived localparam: DATA_W+PAR_W+1. Equals 8 for DATA_W=4.
- CNT_W, 16: width of each error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode_in  in  1  0 = encode, 1 = decode; sampled with the input beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  CODE_W  decode: received codeword; encode: data in [DATA_W-1:0], upper bits ignored.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_mode  out  1  mode of the output beat.
- out_code  out  CODE_W  encode: codeword; decode: corrected codeword.
- out_data  out  DATA_W  extracted data (decode) or echoed input data (encode).
- out_syndrome  out  PAR_W  decode syndrome; 0 in encode.
- out_err_single  out  1  decode beat had a correctable error.
- out_err_double  out  1  decode beat had an uncorrectable error.
- cnt_single  out  CNT_W  saturating count of single errors.
- cnt_double  out  CNT_W  saturating count of double errors.
- cnt_clr  in  1  synchronous clear of both counters.

Behaviour:
- Codeword layout: bit i of the code is Hamming position i, for i = 1..N with N = DATA_W+PAR_W.
  - Parity bit p(2^k) sits at position 2^k and is the XOR of all positions whose index has bit k set.
  - Data bits fill the remaining positions in ascending order, starting from data bit 0.
  - Bit 0 holds overall parity: the XOR of positions 1..N.
- Decode, with syndrome s = XOR of the indices of all set positions 1..N, and P = XOR of all CODE_W bits:
  - s=0, P=0: no error.
  - s=0, P=1: single error in bit 0; correct bit 0.
  - s!=0, P=1, s<=N: single error; flip bit s.
  - s!=0, P=1, s>N: double error.
  - s!=0, P=0: double error.
  - On a double error, out_code and out_data pass through uncorrected.
- Encode: out_err_single, out_err_double and out_syndrome are all 0.
- Pipeline: two register stages (S1: syndrome/parity compute; S2: correct/format).
  - Latency is 2 cycles from input accept to out_valid when not stalled.
  - Throughput is 1 beat per cycle.
- Handshake:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1; a combinational path from out_ready is permitted.
  - Once out_valid is asserted, output data is held stable until accepted.
  - Beat order is preserved; no beat is dropped or duplicated.
- Counters:
  - Increment on an accepted output beat (out_valid && out_ready) with out_mode=1 and the matching error flag set.
  - Saturate at all-ones.
  - cnt_clr in the same cycle as an increment: clear wins.
- Reset (async assert, sync deassert assumed upstream):
  - All stage valids, outputs and counters go to 0.
  - in_ready=1 after reset.
  - Reset mid-operation discards in-flight beats.

Test Plan:
- Encode, DATA_W=4: in_data=0x6 -> out_code=8'h66, out_data=0110. in_data=0x1 -> out_code=8'h0F. out_valid rises exactly 2 cycles after accept.
- Decode clean and corrected:
  - 8'h66 -> data 0110, syndrome 0, no flags.
  - 8'h46 (bit 5 flipped) -> syndrome 5, err_single=1, out_code=8'h66, data 0110.
  - 8'h67 (bit 0 flipped) -> syndrome 0, err_single=1, out_code=8'h66.
- Decode double: 8'h44 (bits 5 and 1 flipped) -> syndrome 4, err_double=1, out_code=8'h44, data 0100, cnt_double increments by 1.
- Backpressure: out_ready=0, offer 3 beats back-to-back.
  - The first two are accepted; in_ready=0 on the third.
  - The first output is held stable.
  - Raise out_ready -> all 3 beats emerge in order, one per cycle.
- Counters with CNT_W=2: five single-error decodes -> cnt_single saturates at 3. cnt_clr together with a sixth error -> cnt_single=0 next cycle.
- DATA_W=8 (CODE_W=13): force syndrome 13 (out of range) with odd P -> err_double=1, no bit flip. Assert rst_n=0 with both stages full -> out_valid=0 immediately, counters 0, in_ready=1.
